// File: rtl/ni_pkt_gen_axi_if.sv
// Beat stream from the AXI slave and flit stream to the router for ni_pkt_gen_axi.
// master drives beats and flit_ready; slave is the packet generator.
interface ni_pkt_gen_axi_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int VC_WIDTH     = 2,
    parameter int PKT_SZ_WIDTH = 9
);
    logic                    in_valid;
    logic                    in_ready;
    logic [VC_WIDTH-1:0]     in_vc_id;
    logic                    in_req_new;
    logic                    in_req_last;
    logic [PKT_SZ_WIDTH-1:0] in_pkt_sz;
    logic [DATA_WIDTH-1:0]   in_data;

    logic                    flit_valid;
    logic                    flit_ready;
    logic [1:0]              flit_type;
    logic [VC_WIDTH-1:0]     flit_vc;
    logic [DATA_WIDTH-1:0]   flit_data;

    modport master (
        output in_valid, in_vc_id, in_req_new, in_req_last, in_pkt_sz, in_data, flit_ready,
        input  in_ready, flit_valid, flit_type, flit_vc, flit_data
    );

    modport slave (
        input  in_valid, in_vc_id, in_req_new, in_req_last, in_pkt_sz, in_data, flit_ready,
        output in_ready, flit_valid, flit_type, flit_vc, flit_data
    );
endinterface

// File: rtl/ni_pkt_gen_axi.sv
// Turns AXI write beats into HEAD/BODY/TAIL/HEAD_TAIL NoC flits via a 2-entry FIFO.
// Optional length checking against in_pkt_sz is enabled by macro PKT_GEN_LEN_CHECK_EN.
module ni_pkt_gen_axi #(
    parameter int DATA_WIDTH   = 32,
    parameter int VC_WIDTH     = 2,
    parameter int X_WIDTH      = 2,
    parameter int Y_WIDTH      = 2,
    parameter int PKT_SZ_WIDTH = 9
) (
    input  logic              clk_axi,
    input  logic              arst_axi,
    ni_pkt_gen_axi_if.slave   bus,
    output logic              len_err,
    output logic              busy
);
    localparam int SZ_MSB = DATA_WIDTH - 1 - X_WIDTH - Y_WIDTH;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_PKT  = 1'b1;

    localparam logic [1:0] T_HEAD      = 2'b00;
    localparam logic [1:0] T_BODY      = 2'b01;
    localparam logic [1:0] T_TAIL      = 2'b10;
    localparam logic [1:0] T_HEAD_TAIL = 2'b11;

    typedef struct packed {
        logic [1:0]            ftype;
        logic [VC_WIDTH-1:0]   vc;
        logic [DATA_WIDTH-1:0] data;
    } flit_t;

    logic [0:0]          state;
    logic [VC_WIDTH-1:0] vc_lock;
    flit_t               fifo_mem [2];
    logic                wr_ptr;
    logic                rd_ptr;
    logic [1:0]          fifo_cnt;
    logic                fifo_full;
    logic                fifo_empty;
    logic                push;
    logic                pop;
    logic                is_head;
    logic                is_tail;
    logic                err_nxt;
    flit_t               flit_in;
    flit_t               flit_out;

    assign fifo_full  = (fifo_cnt == 2'd2);
    assign fifo_empty = (fifo_cnt == 2'd0);
    assign push       = bus.in_valid && bus.in_ready;
    assign pop        = bus.flit_valid && bus.flit_ready;
    assign is_head    = (state == S_IDLE);

    assign bus.in_ready = ~fifo_full;
    assign busy         = (state == S_PKT) || ~fifo_empty;

`ifdef PKT_GEN_LEN_CHECK_EN
    // rem_cnt holds flits still owed after the most recent beat of the open packet
    logic [PKT_SZ_WIDTH-1:0] rem_cnt;
    logic                    cnt_done;

    always_comb begin
        if (is_head)
            cnt_done = (bus.in_pkt_sz <= PKT_SZ_WIDTH'(1));
        else
            cnt_done = (rem_cnt == PKT_SZ_WIDTH'(1));
        is_tail = cnt_done || bus.in_req_last;
        err_nxt = (bus.in_req_last != cnt_done) || (is_head && !bus.in_req_new);
    end

    always_ff @(posedge clk_axi or posedge arst_axi) begin
        if (arst_axi) begin
            rem_cnt <= '0;
        end else if (push) begin
            if (is_tail)
                rem_cnt <= '0;
            else if (is_head)
                rem_cnt <= bus.in_pkt_sz - PKT_SZ_WIDTH'(1);
            else
                rem_cnt <= rem_cnt - PKT_SZ_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_axi or posedge arst_axi) begin
        if (arst_axi)
            len_err <= 1'b0;
        else
            len_err <= push && err_nxt;
    end
`else
    logic unused_len_chk;

    always_comb begin
        is_tail = bus.in_req_last;
        err_nxt = 1'b0;
    end

    assign unused_len_chk = bus.in_req_new ^ err_nxt;
    assign len_err        = 1'b0;
`endif

    // Head flits carry the burst length just below the X/Y destination bits
    always_comb begin
        flit_in.data = bus.in_data;
        if (is_head) begin
            flit_in.data[SZ_MSB -: PKT_SZ_WIDTH] = bus.in_pkt_sz;
            flit_in.vc    = bus.in_vc_id;
            flit_in.ftype = is_tail ? T_HEAD_TAIL : T_HEAD;
        end else begin
            flit_in.vc    = vc_lock;
            flit_in.ftype = is_tail ? T_TAIL : T_BODY;
        end
    end

    always_ff @(posedge clk_axi or posedge arst_axi) begin
        if (arst_axi) begin
            state   <= S_IDLE;
            vc_lock <= '0;
        end else if (push) begin
            if (is_head)
                vc_lock <= bus.in_vc_id;
            state <= is_tail ? S_IDLE : S_PKT;
        end
    end

    always_ff @(posedge clk_axi or posedge arst_axi) begin
        if (arst_axi) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_cnt    <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= flit_in;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Zero the flit fields when empty so the router never sees stale entries
    assign flit_out       = fifo_empty ? '0 : fifo_mem[rd_ptr];
    assign bus.flit_valid = ~fifo_empty;
    assign bus.flit_type  = flit_out.ftype;
    assign bus.flit_vc    = flit_out.vc;
    assign bus.flit_data  = flit_out.data;
endmodule

// File: doc/ni_pkt_gen_axi.md
# ni_pkt_gen_axi

Packet generator stage in the network interface, on the AXI clock domain. It sits directly downstream of the AXI slave interface. It consumes that interface's per-beat write request stream (valid/ready, vc id, new/last markers, packet size, data) and turns each burst into a typed NoC packet: HEAD, BODY, TAIL or HEAD_TAIL flits. Flits are staged in a 2-entry output FIFO, which decouples the AXI side from router back-pressure at full throughput.

## Interface
Parameters:
- DATA_WIDTH, 32, flit payload width (equals AXI data width)
- VC_WIDTH, 2, virtual channel id width
- X_WIDTH, 2, destination X field width
- Y_WIDTH, 2, destination Y field width
- PKT_SZ_WIDTH, 9, packet size field width (holds 1..256 flits)

Ports:
- clk_axi  in  1  clock
- arst_axi  in  1  asynchronous active-high reset
- in_valid  in  1  beat valid from AXI slave
- in_ready  out  1  beat accepted when in_valid && in_ready
- in_vc_id  in  VC_WIDTH  target virtual channel
- in_req_new  in  1  first beat of burst
- in_req_last  in  1  last beat of burst (AXI wlast)
- in_pkt_sz  in  PKT_SZ_WIDTH  burst length in flits (awlen+1)
- in_data  in  DATA_WIDTH  beat payload
- flit_valid  out  1  flit available to router
- flit_ready  in  1  router accepts flit
- flit_type  out  2  00 HEAD, 01 BODY, 10 TAIL, 11 HEAD_TAIL
- flit_vc  out  VC_WIDTH  flit virtual channel
- flit_data  out  DATA_WIDTH  flit payload
- len_err  out  1  one-cycle pulse on length mismatch
- busy  out  1  packet open or FIFO non-empty

## Operation
- FSM states IDLE and PKT. Reset state is IDLE.
- in_ready = ~fifo_full. The slave's wready therefore follows FIFO space.
- Accepted beat in IDLE is a head:
  - Latch vc_id into vc_lock.
  - flit_data = in_data, with bits [DATA_WIDTH-1-X_WIDTH-Y_WIDTH -: PKT_SZ_WIDTH] overwritten by in_pkt_sz.
  - X/Y destination occupy the top X_WIDTH+Y_WIDTH bits and pass through unchanged.
  - Type is HEAD_TAIL if the head is also the tail, else HEAD, and the FSM goes to PKT.
  - in_req_new=0 on a head beat is still treated as a head.
- Accepted beat in PKT:
  - flit_data = in_data and flit_vc = vc_lock; in_vc_id and in_req_new are ignored.
  - Type is TAIL if this beat is the tail (FSM returns to IDLE), else BODY.
- Tail determination depends on configuration (see below).
- FIFO: 2 entries of {type, vc, data}, no bypass.
  - Push = in_valid && in_ready. Pop = flit_valid && flit_ready.
  - Simultaneous push and pop when full is not possible, because in_ready=0. Simultaneous push and pop with 1 entry keeps the count at 1.
- busy = (state==PKT) || ~fifo_empty.
- Reset mid-packet: FSM to IDLE, FIFO flushed, counter 0. A partially sent packet is dropped with no TAIL emitted.

## Timing
- Reset values: in_ready=1, flit_valid=0, flit_type=00, flit_vc=0, flit_data=0, len_err=0, busy=0.
- Latency: a beat accepted in cycle N is presented on flit_valid in cycle N+1.
- Throughput: 1 flit/cycle when flit_ready is held high.
- flit_valid, flit_type, flit_vc and flit_data hold stable while flit_valid && ~flit_ready.
- len_err is registered and asserts in the cycle after the offending beat is accepted.

## Configuration
- Macro PKT_GEN_LEN_CHECK_EN.
- Defined:
  - A remaining-flit counter (PKT_SZ_WIDTH) loads in_pkt_sz-1 on the head and decrements on each PKT beat.
  - Tail = (counter reaches 0 on this beat) || in_req_last.
  - len_err pulses when in_req_last disagrees with the counter: an early last truncates the packet; a missing last closes it anyway, and the next beat starts a new head.
  - len_err also pulses on a head with in_req_new=0.
- Undefined:
  - No counter.
  - Tail = in_req_last only; a head beat with in_req_last=1 is HEAD_TAIL.
  - in_pkt_sz is still inserted into the head.
  - len_err is tied to 0.

## Test plan
- Single beat, pkt_sz=1, last=1, vc=2, data=0xC000_0000, flit_ready=1 -> one HEAD_TAIL next cycle; vc=2; size field=1; len_err=0; busy falls after pop.
- 4-beat burst, pkt_sz=4, data 0x4000_0000, 1, 2, 3 (last on beat 4) -> HEAD (size 4), BODY, BODY, TAIL on consecutive cycles, all vc_lock.
- Same burst with flit_ready=0 -> two flits buffered, then in_ready=0; flit_data stable; on release, all 4 flits drain in order.
- With PKT_GEN_LEN_CHECK_EN, pkt_sz=4, last on beat 2 -> HEAD then TAIL; len_err pulses once; next beat becomes a HEAD.
- in_vc_id changed 1→3 on the body beat of a 3-beat packet -> all flits carry vc=1.
- arst_axi asserted after the head of a 4-flit packet -> flit_valid=0 and busy=0 immediately; the next beat is emitted as a HEAD.
